tmds_serial_gearbox: RTL
========================

Name: tmds_serial_gearbox

Overview:
- Generalised parallel-to-serial gearbox for the HDMI transmit path.
- Takes one WORD_W-bit word per lane for LANES lanes (TMDS data ×3 + clock = 4 by default).
- Emits OUT_W bits per lane per clock, LSB first, to feed per-lane ODDR/OBUFDS primitives (OUT_W=2 DDR, OUT_W=1 SDR).
- Adds what the fixed 4×10-bit DDR shifter lacks:
  - ready/valid input with a one-word holding buffer;
  - idle-word insertion on underrun, with underrun count;
  - per-lane polarity inversion;
  - a frame-start marker.

Parameters:
LANES, 4, number of serial lanes
WORD_W, 10, bits per lane per word
OUT_W, 2, bits per lane per clock; WORD_W % OUT_W must be 0 and PHASES = WORD_W/OUT_W >= 2
IDLE_WORD, 10'b1101010100, word loaded on every lane when no data is buffered (WORD_W bits)
INVERT, 0, LANES-bit mask; bit i=1 inverts all dout bits of lane i

Ports:
clk_shift  in  1  serial word clock (pixel clock × PHASES)
reset  in  1  synchronous, active-high
in_valid  in  1  in_data holds a word for all lanes
in_ready  out  1  block accepts in_data this cycle
in_data  in  LANES*WORD_W  lane i at [i*WORD_W +: WORD_W]
dout  out  LANES*OUT_W  lane i at [i*OUT_W +: OUT_W]; bit 0 is transmitted first
word_start  out  1  high while dout carries chunk 0 of a word
underrun  out  1  one-cycle pulse: idle word loaded because buffer was empty
underrun_cnt  out  16  saturating count of underrun pulses

Behaviour:
- Reset (sync, active-high): phase<=PHASES-1, shift regs<=0, buf_full<=0, started<=0, word_start<=0, underrun<=0, underrun_cnt<=0.
  - dout = 0 ^ INVERT-expanded mask while in reset.
  - Reset mid-word discards the buffer and the partial word. No partial chunk is emitted afterwards.
- Phase counter:
  - Runs 0..PHASES-1, increments every cycle, wraps to 0.
  - Load event = cycle with phase==PHASES-1.
- Handshake:
  - in_ready = !buf_full || load event (combinational).
  - Accept = in_valid && in_ready. An accepted word is written to the buffer.
  - in_data is ignored when not accepted.
  - in_valid may drop without acceptance (no stickiness required).
- Load event, at the clock edge:
  - Each lane shift register <= buf_full ? buf lane : IDLE_WORD.
  - buf_full <= accept this cycle. If buffer-to-shift transfer and a new accept coincide, the new word goes into the buffer; no loss, no duplicate.
  - If the buffer was empty and started=1: underrun<=1 and underrun_cnt increments, saturating at 16'hFFFF. Otherwise underrun<=0.
  - word_start<=1.
- Non-load cycle, at the clock edge:
  - Shift registers shift right by OUT_W with zero fill.
  - word_start<=0; underrun<=0.
  - buf_full <= buf_full || accept.
- started is set on the first accept and cleared only by reset. No underruns are counted before the first word.
- dout lane i = shift_i[OUT_W-1:0] ^ {OUT_W{INVERT[i]}}. Purely from flops; no combinational path from inputs.
- Timing:
  - A word accepted while the buffer is empty, at a non-load cycle, appears at the next load edge.
  - Chunk k (bits [k*OUT_W +: OUT_W]) is on dout during the k-th cycle after that edge, k=0..PHASES-1.
  - Minimum latency from accept to chunk 0 is 1 cycle; maximum is PHASES cycles.
- Sustained throughput is one word per PHASES cycles. Upstream holding in_valid high sees in_ready pulse once per frame after the buffer fills.
- The first load after reset occurs in the first cycle after reset deasserts (phase starts at PHASES-1). With no word yet, IDLE_WORD is emitted and underrun stays 0.

Test Plan:
- Defaults; hold reset 3 cycles, release with in_valid=0 -> word_start at cycle 1 and every 5 cycles; lane0 dout chunks are 2'b00,2'b01,2'b01,2'b01,2'b11 (IDLE_WORD LSB first); underrun and underrun_cnt stay 0.
- Present lane words 10'h3FF,10'h000,10'h155,10'h2AA, in_valid held one cycle at phase 2 -> accepted; next word_start frame gives lane0 five 2'b11, lane1 five 2'b00, lane2 five 2'b01, lane3 five 2'b10.
- in_valid held high with an incrementing lane0 word 10'h001,10'h002,... -> in_ready high once per 5 cycles after the first fill; every word serialised exactly once, in order, with no idle frames.
- After streaming, drop in_valid for 3 frames -> three underrun pulses, each coincident with word_start; underrun_cnt=3; IDLE_WORD frames emitted.
- INVERT=4'b1000, lane3 word 10'h000 -> lane3 dout 2'b11 on all 5 chunks; other lanes unaffected.
- Assert reset at phase 2 with the buffer full -> in the following cycles dout=INVERT mask, buf_full=0, underrun_cnt=0, and the buffered word is never emitted.

Source files
------------

// File: rtl/tmds_serial_gearbox.sv
// Parallel-to-serial gearbox for HDMI lanes: one WORD_W-bit word per lane in, OUT_W bits per lane out per clock.
// Adds a one-word ready/valid buffer, idle-word insertion on underrun, per-lane polarity and a word-start marker.
module tmds_serial_gearbox #(
  parameter int unsigned       LANES     = 4,
  parameter int unsigned       WORD_W    = 10,
  parameter int unsigned       OUT_W     = 2,
  parameter logic [WORD_W-1:0] IDLE_WORD = 10'b1101010100,
  parameter logic [LANES-1:0]  INVERT    = '0
) (
  input  logic                     clk_shift,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*WORD_W-1:0]  in_data,
  output logic [LANES*OUT_W-1:0]   dout,
  output logic                     word_start,
  output logic                     underrun,
  output logic [15:0]              underrun_cnt
);

  localparam int unsigned PHASES  = WORD_W / OUT_W;
  localparam int unsigned PH_W    = (PHASES > 1) ? $clog2(PHASES) : 1;
  localparam logic [PH_W-1:0] LAST_PH = PH_W'(PHASES - 1);

  if ((WORD_W % OUT_W) != 0 || PHASES < 2) begin : g_bad_params
    $error("tmds_serial_gearbox: WORD_W must be a multiple of OUT_W with at least two phases");
  end

  logic [PH_W-1:0]         phase_q;
  logic [LANES*WORD_W-1:0] hold_q;
  logic                    hold_full_q;
  logic                    started_q;
  logic [WORD_W-1:0]       shift_q [LANES];
  logic                    load_c;
  logic                    accept_c;

  assign load_c   = (phase_q == LAST_PH);
  assign in_ready = !hold_full_q || load_c;
  assign accept_c = in_valid && in_ready;

  // Holding buffer payload; validity is tracked by hold_full_q, so no reset needed.
  always_ff @(posedge clk_shift) begin
    if (accept_c) begin
      hold_q <= in_data;
    end
  end

  // Phase counter, buffer flag, shifters and status flags.
  always_ff @(posedge clk_shift) begin
    if (reset) begin
      phase_q      <= LAST_PH;
      hold_full_q  <= 1'b0;
      started_q    <= 1'b0;
      word_start   <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= 16'd0;
      for (int unsigned i = 0; i < LANES; i++) begin
        shift_q[i] <= '0;
      end
    end else begin
      phase_q <= load_c ? '0 : phase_q + PH_W'(1);
      if (accept_c) begin
        started_q <= 1'b1;
      end
      if (load_c) begin
        for (int unsigned i = 0; i < LANES; i++) begin
          shift_q[i] <= hold_full_q ? hold_q[i*WORD_W +: WORD_W] : IDLE_WORD;
        end
        hold_full_q <= accept_c;
        word_start  <= 1'b1;
        // Underruns only count once real traffic has started.
        if (!hold_full_q && started_q) begin
          underrun <= 1'b1;
          if (underrun_cnt != 16'hFFFF) begin
            underrun_cnt <= underrun_cnt + 16'd1;
          end
        end else begin
          underrun <= 1'b0;
        end
      end else begin
        for (int unsigned i = 0; i < LANES; i++) begin
          shift_q[i] <= shift_q[i] >> OUT_W;
        end
        hold_full_q <= hold_full_q || accept_c;
        word_start  <= 1'b0;
        underrun    <= 1'b0;
      end
    end
  end

  // Output chunk per lane with static polarity flip; driven only by flops.
  always_comb begin
    dout = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      dout[i*OUT_W +: OUT_W] = shift_q[i][OUT_W-1:0] ^ {OUT_W{INVERT[i]}};
    end
  end

endmodule
